// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded instruction, resolves operand
// forwarding from EX/MEM and MEM/WB, and handles stall, flush and bubbles.

module id_ex_fwd #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 4
) (
  input  logic [RA_W-1:0]   i_rs,
  input  logic [DATA_W-1:0] i_rf,
  input  logic              i_exmem_we,
  input  logic [RA_W-1:0]   i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_data,
  input  logic              i_memwb_we,
  input  logic [RA_W-1:0]   i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_data,
  output logic [DATA_W-1:0] o_val
);
  always_comb begin
    o_val = i_rf;
    if (i_rs == '0)                             o_val = '0;
    else if (i_exmem_we && i_exmem_rd == i_rs)  o_val = i_exmem_data;
    else if (i_memwb_we && i_memwb_rd == i_rs)  o_val = i_memwb_data;
  end
endmodule

module id_ex_stage #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 5,
  parameter int RA_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_valid,
  input  logic [OP_W-1:0]   i_id_aluOp,
  input  logic [RA_W-1:0]   i_id_rs1,
  input  logic [RA_W-1:0]   i_id_rs2,
  input  logic [RA_W-1:0]   i_id_rd,
  input  logic [DATA_W-1:0] i_id_rdata1,
  input  logic [DATA_W-1:0] i_id_rdata2,
  input  logic              i_id_regWrite,
  input  logic              i_id_useImm,
  input  logic [DATA_W-1:0] i_id_imm,
  input  logic              i_exmem_regWrite,
  input  logic [RA_W-1:0]   i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_result,
  input  logic              i_memwb_regWrite,
  input  logic [RA_W-1:0]   i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_data,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic              o_ex_valid,
  output logic [OP_W-1:0]   o_ex_aluOp,
  output logic [DATA_W-1:0] o_ex_srcA,
  output logic [DATA_W-1:0] o_ex_srcB,
  output logic [RA_W-1:0]   o_ex_rd,
  output logic              o_ex_regWrite,
  output logic [15:0]       o_stall_cnt,
  output logic [15:0]       o_flush_cnt
);
  logic              r_valid, r_regWrite, r_useImm;
  logic [OP_W-1:0]   r_aluOp;
  logic [DATA_W-1:0] r_srcA, r_srcB;
  logic [RA_W-1:0]   r_rd, r_rs1, r_rs2;
  logic [15:0]       r_stall_cnt, r_flush_cnt;

  // Forward paths: [0]/[1] decode rs1/rs2, [2]/[3] held rs1/rs2 (refresh
  // during stall; a non-matching held operand keeps its current value).
  logic [3:0][RA_W-1:0]   w_rs;
  logic [3:0][DATA_W-1:0] w_rf;
  logic [3:0][DATA_W-1:0] w_fwd;

  assign w_rs = {r_rs2, r_rs1, i_id_rs2, i_id_rs1};
  assign w_rf = {r_srcB, r_srcA, i_id_rdata2, i_id_rdata1};

  for (genvar g = 0; g < 4; g++) begin : g_fwd
    id_ex_fwd #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd (
      .i_rs         (w_rs[g]),
      .i_rf         (w_rf[g]),
      .i_exmem_we   (i_exmem_regWrite),
      .i_exmem_rd   (i_exmem_rd),
      .i_exmem_data (i_exmem_result),
      .i_memwb_we   (i_memwb_regWrite),
      .i_memwb_rd   (i_memwb_rd),
      .i_memwb_data (i_memwb_data),
      .o_val        (w_fwd[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid     <= 1'b0;
      r_regWrite  <= 1'b0;
      r_useImm    <= 1'b0;
      r_aluOp     <= '0;
      r_srcA      <= '0;
      r_srcB      <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (i_flush || (!i_stall && !i_id_valid)) begin
      r_valid    <= 1'b0;
      r_regWrite <= 1'b0;
      r_useImm   <= 1'b0;
      r_aluOp    <= '0;
      r_srcA     <= '0;
      r_srcB     <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      if (i_flush && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
    end else if (i_stall) begin
      r_srcA <= w_fwd[2];
      if (!r_useImm) r_srcB <= w_fwd[3];
      if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end else begin
      r_valid    <= 1'b1;
      r_regWrite <= i_id_regWrite;
      r_useImm   <= i_id_useImm;
      r_aluOp    <= i_id_aluOp;
      r_srcA     <= w_fwd[0];
      r_srcB     <= i_id_useImm ? i_id_imm : w_fwd[1];
      r_rd       <= i_id_rd;
      r_rs1      <= i_id_rs1;
      r_rs2      <= i_id_rs2;
    end
  end

  assign o_ex_valid    = r_valid;
  assign o_ex_aluOp    = r_aluOp;
  assign o_ex_srcA     = r_srcA;
  assign o_ex_srcB     = r_srcB;
  assign o_ex_rd       = r_rd;
  assign o_ex_regWrite = r_regWrite;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the pipeline slot.
module tb_id_ex_stage;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 0, id_regWrite = 0, id_useImm = 0;
  logic [4:0] id_aluOp = '0;
  logic [3:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [7:0] id_rdata1 = '0, id_rdata2 = '0, id_imm = '0;
  logic       exmem_we = 0, memwb_we = 0, stall = 0, flush = 0;
  logic [3:0] exmem_rd = '0, memwb_rd = '0;
  logic [7:0] exmem_res = '0, memwb_data = '0;

  logic       ex_valid, ex_regWrite;
  logic [4:0] ex_aluOp;
  logic [7:0] ex_srcA, ex_srcB;
  logic [3:0] ex_rd;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0, failures = 0;

  id_ex_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_aluOp(id_aluOp),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
    .i_id_rdata1(id_rdata1), .i_id_rdata2(id_rdata2), .i_id_regWrite(id_regWrite),
    .i_id_useImm(id_useImm), .i_id_imm(id_imm),
    .i_exmem_regWrite(exmem_we), .i_exmem_rd(exmem_rd), .i_exmem_result(exmem_res),
    .i_memwb_regWrite(memwb_we), .i_memwb_rd(memwb_rd), .i_memwb_data(memwb_data),
    .i_stall(stall), .i_flush(flush),
    .o_ex_valid(ex_valid), .o_ex_aluOp(ex_aluOp), .o_ex_srcA(ex_srcA),
    .o_ex_srcB(ex_srcB), .o_ex_rd(ex_rd), .o_ex_regWrite(ex_regWrite),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Model: the instruction currently sitting in the slot.
  typedef struct {
    bit       v, we, imm;
    bit [4:0] op;
    bit [7:0] a, b;
    bit [3:0] rd, rs1, rs2;
  } slot_t;
  slot_t m;
  int    m_scnt, m_fcnt;

  function automatic bit [7:0] fwd(bit [3:0] rs, bit [7:0] rf);
    if (rs == 0) return 8'h00;
    if (exmem_we && exmem_rd == rs) return exmem_res;
    if (memwb_we && memwb_rd == rs) return memwb_data;
    return rf;
  endfunction

  function automatic int sat(int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  task automatic model_edge();
    slot_t n;
    n = '{default: 0};
    if (flush) begin
      m = n;
      m_fcnt = sat(m_fcnt);
    end else if (stall) begin
      m.a = fwd(m.rs1, m.a);
      if (!m.imm) m.b = fwd(m.rs2, m.b);
      m_scnt = sat(m_scnt);
    end else if (!id_valid) begin
      m = n;
    end else begin
      n.v = 1; n.we = id_regWrite; n.imm = id_useImm; n.op = id_aluOp;
      n.rd = id_rd; n.rs1 = id_rs1; n.rs2 = id_rs2;
      n.a = fwd(id_rs1, id_rdata1);
      n.b = id_useImm ? id_imm : fwd(id_rs2, id_rdata2);
      m = n;
    end
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".valid"}, 16'(ex_valid), 16'(m.v));
    chk({tag, ".op"},    16'(ex_aluOp), 16'(m.op));
    chk({tag, ".srcA"},  16'(ex_srcA),  16'(m.a));
    chk({tag, ".srcB"},  16'(ex_srcB),  16'(m.b));
    chk({tag, ".rd"},    16'(ex_rd),    16'(m.rd));
    chk({tag, ".we"},    16'(ex_regWrite), 16'(m.we));
    chk({tag, ".scnt"},  stall_cnt, 16'(m_scnt));
    chk({tag, ".fcnt"},  flush_cnt, 16'(m_fcnt));
  endtask

  task automatic step(string tag, bit do_chk = 1);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    if (do_chk) chk_all(tag);
  endtask

  task automatic idle_writers();
    exmem_we = 0; memwb_we = 0; exmem_rd = 0; memwb_rd = 0;
    exmem_res = 0; memwb_data = 0;
  endtask

  task automatic load(bit [4:0] op, bit [3:0] rs1, bit [7:0] d1,
                      bit [3:0] rs2, bit [7:0] d2, bit [3:0] rd);
    id_valid = 1; id_aluOp = op; id_rs1 = rs1; id_rdata1 = d1;
    id_rs2 = rs2; id_rdata2 = d2; id_rd = rd; id_regWrite = 1; id_useImm = 0;
  endtask

  initial begin
    m = '{default: 0}; m_scnt = 0; m_fcnt = 0;
    #13 rst_n = 1'b1;
    // Fill the slot with something non-zero, then reset mid-cycle.
    load(5'b00110, 4'd1, 8'h3C, 4'd2, 8'h5A, 4'd7);
    stall = 0; flush = 0;
    step("pre");
    stall = 1; step("pre_stall"); stall = 0;
    #3 rst_n = 1'b0;
    #1;
    m = '{default: 0}; m_scnt = 0; m_fcnt = 0;
    chk_all("async_rst");
    #2 rst_n = 1'b1;

    // Reset/load
    load(5'b00100, 4'd3, 8'h41, 4'd4, 8'h02, 4'd6);
    step("load");
    chk("load.op_k",   16'(ex_aluOp), 16'h04);
    chk("load.srcA_k", 16'(ex_srcA),  16'h41);
    chk("load.vld_k",  16'(ex_valid), 16'h1);

    // Forward priority
    load(5'b00001, 4'd5, 8'h11, 4'd6, 8'h22, 4'd1);
    exmem_we = 1; exmem_rd = 5; exmem_res = 8'hAA;
    memwb_we = 1; memwb_rd = 5; memwb_data = 8'h55;
    step("fwd_ex");
    chk("fwd_ex.k", 16'(ex_srcA), 16'hAA);
    exmem_we = 0;
    step("fwd_wb");
    chk("fwd_wb.k", 16'(ex_srcA), 16'h55);
    id_rs1 = 0; exmem_we = 1; exmem_rd = 0; memwb_rd = 0;
    step("fwd_r0");
    chk("fwd_r0.k", 16'(ex_srcA), 16'h00);

    // Immediate wins over a matching writer on rs2
    id_useImm = 1; id_imm = 8'h7F; id_rs2 = 4'd9; id_rdata2 = 8'h01;
    exmem_we = 1; exmem_rd = 9; exmem_res = 8'hEE;
    step("imm");
    chk("imm.k", 16'(ex_srcB), 16'h7F);
    idle_writers();

    // Stall refresh
    load(5'b01010, 4'd2, 8'h10, 4'd3, 8'h20, 4'd4);
    step("st_load");
    id_aluOp = 5'b11111; id_rdata1 = 8'hFF; stall = 1;
    step("st1");
    memwb_we = 1; memwb_rd = 2; memwb_data = 8'h99;
    step("st2");
    chk("st2.srcA_k", 16'(ex_srcA), 16'h99);
    idle_writers();
    step("st3");
    chk("st3.op_k",   16'(ex_aluOp), 16'h0A);
    chk("st3.scnt_k", stall_cnt, 16'd3);

    // Flush beats stall
    flush = 1;
    step("fl");
    chk("fl.vld_k",  16'(ex_valid), 16'h0);
    chk("fl.fcnt_k", flush_cnt, 16'd1);
    chk("fl.scnt_k", stall_cnt, 16'd3);
    flush = 0; stall = 0;

    // Randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 9) != 0);
      id_aluOp = 5'($urandom); id_rs1 = 4'($urandom_range(0, 3));
      id_rs2 = 4'($urandom_range(0, 3)); id_rd = 4'($urandom);
      id_rdata1 = 8'($urandom); id_rdata2 = 8'($urandom);
      id_regWrite = 1'($urandom); id_useImm = ($urandom_range(0, 3) == 0);
      id_imm = 8'($urandom);
      exmem_we = 1'($urandom); exmem_rd = 4'($urandom_range(0, 3));
      exmem_res = 8'($urandom);
      memwb_we = 1'($urandom); memwb_rd = 4'($urandom_range(0, 3));
      memwb_data = 8'($urandom);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      step("rnd");
    end

    // Saturation
    idle_writers(); flush = 0; stall = 1;
    for (int i = 0; i < 70000; i++) step("sat", 0);
    chk_all("sat_end");
    chk("sat.k", stall_cnt, 16'hFFFF);
    step("sat_hold");
    chk("sat_hold.k", stall_cnt, 16'hFFFF);
    stall = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the 8-bit CPU core. It sits directly upstream of the ALU and captures the decoded instruction (`aluOp`, operands, destination) on each clock. It resolves operand forwarding from the EX/MEM and MEM/WB stages and drives the ALU's `aluOp`/`srcA`/`srcB` inputs. It also handles stall and flush, inserts bubbles (`aluOp` = 5'b00000, nop), and keeps saturating stall/flush event counters for debug.

## Interface
- `DATA_W`, 8, operand width; matches ALU `srcA`/`srcB`.
- `OP_W`, 5, ALU opcode width.
- `RA_W`, 4, register-index width; register 0 is hardwired zero.
- `clk` input 1: core clock; all state updates on the rising edge.
- `rst` input 1: reset. One clock; reset is asynchronous and active-low.
- `id_valid` input 1: decode slot holds a real instruction.
- `id_aluOp` input OP_W: decoded ALU operation.
- `id_rs1`, `id_rs2` input RA_W: source register indices.
- `id_rd` input RA_W: destination register index.
- `id_rdata1`, `id_rdata2` input DATA_W: register-file read data.
- `id_regWrite` input 1: instruction writes `id_rd`.
- `id_useImm` input 1: srcB comes from `id_imm` instead of rs2.
- `id_imm` input DATA_W: immediate.
- `exmem_regWrite` input 1, `exmem_rd` input RA_W, `exmem_result` input DATA_W: EX/MEM writer. Carries the low byte of the ALU result.
- `memwb_regWrite` input 1, `memwb_rd` input RA_W, `memwb_data` input DATA_W: MEM/WB writer.
- `stall` input 1: hold the current contents; the upstream stage also holds.
- `flush` input 1: replace the next contents with a bubble.
- `ex_valid` output 1: the ALU inputs carry a real instruction.
- `ex_aluOp` output OP_W: drives ALU `aluOp`.
- `ex_srcA`, `ex_srcB` output DATA_W: drive ALU `srcA`/`srcB`.
- `ex_rd` output RA_W, `ex_regWrite` output 1: passed downstream.
- `stall_cnt` output 16: saturating count of stalled cycles.
- `flush_cnt` output 16: saturating count of flush cycles.

## Operation
- Forward select for operand X (rs = `id_rs1` or `id_rs2`), evaluated in priority order:
  1. rs == 0 → 0.
  2. `exmem_regWrite` && `exmem_rd` == rs → `exmem_result`.
  3. `memwb_regWrite` && `memwb_rd` == rs → `memwb_data`.
  4. Otherwise → register-file read data.
- srcB = `id_imm` when `id_useImm`, otherwise the forwarded rs2 value.
- Next-state priority each edge, highest first:
  - **flush**: load a bubble — `ex_valid`=0, `ex_aluOp`=0, `ex_regWrite`=0, `ex_rd`=0, srcA/srcB=0. `flush_cnt`++.
  - **stall**: keep the instruction, opcode, rd and regWrite.
    - Refresh held operands from writers still in flight, using the same priority rules applied to the held rs1/rs2. Downstream stages keep advancing during a stall.
    - srcB is not refreshed when the held instruction uses an immediate.
    - `stall_cnt`++.
  - **load**: capture the decode slot.
    - If `id_valid`=0, load a bubble (all fields 0).
    - Otherwise load `id_aluOp`, the forwarded srcA/srcB, `id_rd`, and `id_regWrite`.
- Held rs1/rs2/useImm are stored internally for the refresh; they are not outputs.
- Counters saturate at 16'hFFFF. A cycle with both flush and stall counts only as a flush.
- Arithmetic: index comparisons are exact RA_W-bit equality. There is no width conversion; `exmem_result` is already DATA_W.

## Timing
- Latency: one cycle. Decode values present before edge N appear on the `ex_*` outputs after edge N.
- Forwarding uses writer inputs sampled at the same edge as the capture.
- Reset (`rst`=0, asynchronous): every output and all internal state go to 0 immediately. The outputs therefore present a nop bubble.
- Deasserting reset mid-stream: the first edge with `rst`=1 performs a normal load.
- A stall held for K cycles keeps `ex_valid`/`ex_aluOp` constant for K edges and adds K to `stall_cnt` (until saturation).
- A flush during a stall discards the held instruction at that edge.

## Test plan
- **Reset/load**: assert `rst`=0 mid-run → all outputs 0 without waiting for a clock edge. Release reset, then load `id_aluOp`=5'b00100, rs1=3, `id_rdata1`=8'h41 → next cycle `ex_aluOp`=5'b00100, `ex_srcA`=8'h41, `ex_valid`=1.
- **Forward priority**: rs1=5 with `exmem_rd`=5 (`exmem_result`=8'hAA) and `memwb_rd`=5 (`memwb_data`=8'h55), both regWrite=1 → `ex_srcA`=8'hAA. With `exmem_regWrite`=0 → 8'h55. With rs1=0 and matching writers → 8'h00.
- **Immediate**: `id_useImm`=1, `id_imm`=8'h7F, `exmem_rd` == rs2 → `ex_srcB`=8'h7F.
- **Stall refresh**: load rs1=2 with `id_rdata1`=8'h10, then stall 3 cycles.
  - During the second stalled cycle drive `memwb_regWrite`=1, `memwb_rd`=2, `memwb_data`=8'h99 → `ex_srcA` becomes 8'h99 on the next edge.
  - `ex_aluOp` stays unchanged throughout; `stall_cnt`=3.
- **Flush vs stall**: assert flush and stall together with a valid instruction held → next cycle `ex_valid`=0, `ex_aluOp`=5'b00000; `flush_cnt`+1, `stall_cnt` unchanged.
- **Saturation**: hold stall for 70000 cycles → `stall_cnt`=16'hFFFF and it stays there.
